i2c_cmd_sequencer: RTL and testbench
====================================

# i2c_cmd_sequencer

Downstream consumer of the `common_interface` command/write/read channels, acting on the slave side. It accepts one burst command at a time and expands it into byte-level I2C operations (START, device address, register address, data, repeated START, STOP) for the I2C byte engine. It returns read data on the rd channel, then reports completion with a `finish` pulse and a `status` word.

## Interface
Parameters:
- `CSIZE`, 4, command code width.
- `LSIZE`, 24, burst length width, in bytes.
- `DSIZE`, 8, data width (one I2C byte).
- `ASIZE`, 15, address width: `addr[14:8]` = 7-bit device address, `addr[7:0]` = register address.

Ports (`common_interface` slave-side signals, flattened, plus the byte-engine port):
- `clock` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `clk_en` in 1: qualifies every state, counter and handshake update.
- `cmd_vld` in 1: command valid.
- `cmd` in CSIZE: command code.
- `addr` in ASIZE: device and register address.
- `burst_len` in LSIZE: number of data bytes.
- `cmd_ready` out 1: command accepted when `cmd_vld & cmd_ready & clk_en`.
- `finish` out 1: one-cycle completion pulse.
- `status` out 5: result; held until the next command is accepted.
- `wr_vld`, `wr_data[DSIZE]`, `wr_last` in: write stream.
- `wr_ready` out 1: write stream ready.
- `rd_vld`, `rd_data[DSIZE]`, `rd_last` out: read stream.
- `rd_ready` in 1: read stream ready.
- `bc_vld` out 1, `bc_op` out 2 (START/STOP/WRITE/READ), `bc_tx` out 8, `bc_mack` out 1: byte-engine request. `bc_mack` = 1 means the master ACKs the read byte.
- `bc_ready` in 1, `bc_done` in 1, `bc_rx` in 8, `bc_nack` in 1: byte-engine response. `bc_nack` is valid with `bc_done`.

## Operation
Command codes:
- `CMD_WR` = 0: START, device address with W, register address, `burst_len` data bytes, STOP.
- `CMD_RD` = 1: START, device address with W, register address, repeated START, device address with R, `burst_len` read bytes, STOP.
- Any other code is illegal.

State machine: IDLE → START → DEV_W → REG → (WDATA | RSTART → DEV_R → RDATA) → STOP → DONE → IDLE.
- Each state issues exactly one `bc_vld` request, held until `bc_ready`. The state then waits for `bc_done` before advancing.
- `cmd_ready` = 1 only in IDLE. On accept, `addr`, `cmd` and `burst_len` are latched, and the byte counter is loaded with `burst_len`.
- Illegal `cmd`, or `burst_len` = 0: go directly to DONE. No bus traffic. Set status bit 3 (illegal) or bit 4 (zero length).
- WDATA: `wr_ready` = `bc_ready` while a request slot is free. Each accepted `wr_data` becomes `bc_tx`. The counter decrements on each `bc_done`. Exit to STOP when the counter reaches 0. `wr_last` is ignored; the counter is authoritative.
- RDATA: `bc_mack` = 1 for every byte except the final one, which gets 0 (NACK). `bc_rx` is captured into a one-entry hold register and `rd_vld` is raised. The next READ request is not issued until the held byte is accepted (`rd_vld & rd_ready`). `rd_last` = 1 on the final byte.
- NACK on DEV_W/DEV_R: set status bit 1, go to STOP. NACK on REG or a write byte: set status bit 2, go to STOP. Undelivered write bytes are not drained; the master discards them on `finish`.
- Status bits: [0] busy, [1] address NACK, [2] data NACK, [3] illegal cmd, [4] zero length. Bits [4:1] clear on the next command accept.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 in the first cycle after release; `finish`=0, `status`=0, `wr_ready`=0, `rd_vld`=0, `rd_last`=0, `bc_vld`=0, `bc_op`=START, `bc_tx`=0, `bc_mack`=0. State returns to IDLE.
- Command accepted in cycle N: busy=1 and `bc_vld`=1 (START) in cycle N+1.
- DONE lasts exactly one cycle: `finish`=1 and busy=0. `cmd_ready`=1 in the following cycle.
- Illegal or zero-length command accepted in cycle N: `finish` in cycle N+2.
- `clk_en`=0 freezes all state, and all outputs hold their values.
- `bc_vld` and `bc_op`/`bc_tx` are stable while `bc_vld & !bc_ready`. `rd_data` is stable while `rd_vld & !rd_ready`.
- `bc_done` and `bc_ready` arriving in the same cycle: `bc_done` completes the current byte, and the new request is not counted as issued.
- Byte counter is LSIZE wide, so the maximum burst is 2^LSIZE−1 and there is no wrap.
- Reset mid-burst: immediate return to IDLE. No STOP is issued; recovering the bus is the byte engine's responsibility.

## Structure
- Package `i2c_seq_pkg` holds:
  - state enum;
  - `CMD_WR`/`CMD_RD` constants;
  - `bc_op` enum (OP_START, OP_STOP, OP_WRITE, OP_READ);
  - status bit index constants.
- Single module; the read hold register and byte counter are inline. No sub-module.

## Test plan
- WRITE, addr=0x50A3 (device 0x50, reg 0xA3), len=3, data 11/22/33, all ACK → `bc_tx` sequence A0, A3, 11, 22, 33, then STOP; `finish` with status=0.
- READ, addr=0x50A3, len=2, engine returns 5A then C3 → `bc_tx` A0, A3, then RSTART, then A1. `bc_mack` is 1 for the first byte and 0 for the second. `rd_data` 5A then C3, with `rd_last` on C3.
- READ len=2 with `rd_ready` held 0 for 10 cycles → `rd_data`=5A stable and no second READ request issued until accept.
- NACK on device address → STOP follows immediately; status=0b00010; `wr_ready` never asserted.
- cmd=7 → `finish` two cycles after accept, status bit 3 set, `bc_vld` never 1. len=0 → status bit 4 set.
- Reset asserted in WDATA after one of three bytes → `cmd_ready`=1 and `bc_vld`=0 immediately after release; a new WRITE then completes normally.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C command sequencer.
//   state_e   : sequencer FSM states
//   bc_op_e   : byte-engine operation codes
//   CMD_*     : accepted command codes
//   ST_*      : bit positions inside the status word
package i2c_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEV_W, S_REG, S_WDATA,
        S_RSTART, S_DEV_R, S_RDATA, S_STOP, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_STOP  = 2'd1,
        OP_WRITE = 2'd2,
        OP_READ  = 2'd3
    } bc_op_e;

    localparam int unsigned CMD_WR = 0;
    localparam int unsigned CMD_RD = 1;

    localparam int ST_BUSY      = 0;
    localparam int ST_ADDR_NACK = 1;
    localparam int ST_DATA_NACK = 2;
    localparam int ST_ILLEGAL   = 3;
    localparam int ST_ZERO_LEN  = 4;

endpackage

// File: rtl/i2c_cmd_sequencer.sv
// Expands one burst command into byte-level I2C operations for a byte engine.
// Ports:
//   clock, rst, clk_en                 : clock, async active-high reset, global enable
//   cmd_vld/cmd/addr/burst_len/cmd_ready : command channel (addr = {dev[6:0], reg[7:0]})
//   finish, status                     : completion pulse and result word
//   wr_vld/wr_data/wr_last/wr_ready    : write data stream (slave side)
//   rd_vld/rd_data/rd_last/rd_ready    : read data stream (slave side)
//   bc_vld/bc_op/bc_tx/bc_mack/bc_ready: byte-engine request
//   bc_done/bc_rx/bc_nack              : byte-engine completion
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int CSIZE = 4,
    parameter int LSIZE = 24,
    parameter int DSIZE = 8,
    parameter int ASIZE = 15
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             cmd_vld,
    input  logic [CSIZE-1:0] cmd,
    input  logic [ASIZE-1:0] addr,
    input  logic [LSIZE-1:0] burst_len,
    output logic             cmd_ready,
    output logic             finish,
    output logic [4:0]       status,
    input  logic             wr_vld,
    input  logic [DSIZE-1:0] wr_data,
    input  logic             wr_last,
    output logic             wr_ready,
    output logic             rd_vld,
    output logic [DSIZE-1:0] rd_data,
    output logic             rd_last,
    input  logic             rd_ready,
    output logic             bc_vld,
    output logic [1:0]       bc_op,
    output logic [7:0]       bc_tx,
    output logic             bc_mack,
    input  logic             bc_ready,
    input  logic             bc_done,
    input  logic [7:0]       bc_rx,
    input  logic             bc_nack
);

    state_e           state_q, state_d;
    logic [CSIZE-1:0] cmd_q, cmd_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic [LSIZE-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;      // request accepted by engine, awaiting bc_done
    logic             bc_vld_q, bc_vld_d;
    bc_op_e           bc_op_q, bc_op_d;
    logic [7:0]       bc_tx_q, bc_tx_d;
    logic             bc_mack_q, bc_mack_d;
    logic             finish_q, finish_d;
    logic [4:0]       status_q, status_d;
    logic             rd_vld_q, rd_vld_d;
    logic [DSIZE-1:0] rd_data_q, rd_data_d;
    logic             rd_last_q, rd_last_d;

    logic       in_wdata, wr_acc, byte_done, last_byte, cmd_bad;
    logic [7:0] dev_w, dev_r;
    logic       unused_wr_last;

    // The byte counter is authoritative; wr_last carries no information here.
    assign unused_wr_last = wr_last;

    assign dev_w     = {addr_q[ASIZE-1 -: 7], 1'b0};
    assign dev_r     = {addr_q[ASIZE-1 -: 7], 1'b1};
    assign in_wdata  = (state_q == S_WDATA);
    assign byte_done = pend_q & bc_done;
    assign last_byte = (cnt_q == LSIZE'(1));
    assign cmd_bad   = ((cmd != CSIZE'(CMD_WR)) && (cmd != CSIZE'(CMD_RD))) || (burst_len == '0);

    // Write bytes pass straight from the write stream to the engine so that
    // wr_ready tracks bc_ready whenever no byte is in flight.
    assign wr_ready  = in_wdata & ~pend_q & bc_ready;
    assign wr_acc    = wr_vld & wr_ready & clk_en;

    assign cmd_ready = (state_q == S_IDLE) & ~rst;
    assign finish    = finish_q;
    assign status    = status_q;
    assign rd_vld    = rd_vld_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;
    assign bc_vld    = in_wdata ? (wr_vld & ~pend_q) : bc_vld_q;
    assign bc_op     = in_wdata ? OP_WRITE : bc_op_q;
    assign bc_tx     = in_wdata ? 8'(wr_data) : bc_tx_q;
    assign bc_mack   = bc_mack_q;

    always_comb begin
        state_d   = state_q;   cmd_d     = cmd_q;     addr_d    = addr_q;
        cnt_d     = cnt_q;     pend_d    = pend_q;    bc_vld_d  = bc_vld_q;
        bc_op_d   = bc_op_q;   bc_tx_d   = bc_tx_q;   bc_mack_d = bc_mack_q;
        finish_d  = finish_q;  status_d  = status_q;  rd_vld_d  = rd_vld_q;
        rd_data_d = rd_data_q; rd_last_d = rd_last_q;
        if (clk_en) begin
            finish_d = 1'b0;
            if (bc_vld_q && bc_ready) begin
                bc_vld_d = 1'b0;
                pend_d   = 1'b1;
            end
            if (wr_acc)    pend_d = 1'b1;
            if (byte_done) pend_d = 1'b0;
            if (rd_vld_q && rd_ready) begin
                rd_vld_d  = 1'b0;
                rd_last_d = 1'b0;
            end
            unique case (state_q)
                S_IDLE: if (cmd_vld) begin
                    cmd_d    = cmd;
                    addr_d   = addr;
                    cnt_d    = burst_len;
                    status_d = 5'b00001;
                    status_d[ST_ILLEGAL]  = (cmd != CSIZE'(CMD_WR)) && (cmd != CSIZE'(CMD_RD));
                    status_d[ST_ZERO_LEN] = (burst_len == '0);
                    state_d  = S_START;
                    // Bad commands pass through START without a bus request.
                    if (!cmd_bad) begin
                        bc_vld_d = 1'b1; bc_op_d = OP_START; bc_tx_d = 8'h00; bc_mack_d = 1'b0;
                    end
                end
                S_START: begin
                    if (status_q[ST_ILLEGAL] || status_q[ST_ZERO_LEN]) begin
                        state_d = S_DONE; finish_d = 1'b1; status_d[ST_BUSY] = 1'b0;
                    end else if (byte_done) begin
                        state_d  = S_DEV_W;
                        bc_vld_d = 1'b1; bc_op_d = OP_WRITE; bc_tx_d = dev_w; bc_mack_d = 1'b0;
                    end
                end
                S_DEV_W, S_REG, S_WDATA, S_DEV_R: if (byte_done) begin
                    if (bc_nack) begin
                        if (state_q == S_DEV_W || state_q == S_DEV_R) status_d[ST_ADDR_NACK] = 1'b1;
                        else                                          status_d[ST_DATA_NACK] = 1'b1;
                        state_d  = S_STOP;
                        bc_vld_d = 1'b1; bc_op_d = OP_STOP; bc_tx_d = 8'h00; bc_mack_d = 1'b0;
                    end else if (state_q == S_DEV_W) begin
                        state_d  = S_REG;
                        bc_vld_d = 1'b1; bc_op_d = OP_WRITE; bc_tx_d = addr_q[7:0]; bc_mack_d = 1'b0;
                    end else if (state_q == S_REG) begin
                        if (cmd_q == CSIZE'(CMD_WR)) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d  = S_RSTART;
                            bc_vld_d = 1'b1; bc_op_d = OP_START; bc_tx_d = 8'h00; bc_mack_d = 1'b0;
                        end
                    end else if (state_q == S_DEV_R) begin
                        state_d = S_RDATA;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        if (last_byte) begin
                            state_d  = S_STOP;
                            bc_vld_d = 1'b1; bc_op_d = OP_STOP; bc_tx_d = 8'h00; bc_mack_d = 1'b0;
                        end
                    end
                end
                S_RSTART: if (byte_done) begin
                    state_d  = S_DEV_R;
                    bc_vld_d = 1'b1; bc_op_d = OP_WRITE; bc_tx_d = dev_r; bc_mack_d = 1'b0;
                end
                S_RDATA: begin
                    if (byte_done) begin
                        rd_vld_d  = 1'b1;
                        rd_data_d = DSIZE'(bc_rx);
                        rd_last_d = last_byte;
                        cnt_d     = cnt_q - 1'b1;
                        if (last_byte) begin
                            state_d  = S_STOP;
                            bc_vld_d = 1'b1; bc_op_d = OP_STOP; bc_tx_d = 8'h00; bc_mack_d = 1'b0;
                        end
                    end else if (!pend_q && !bc_vld_q && !rd_vld_q) begin
                        // Issue the next read only once the hold register is empty;
                        // the final byte is NACKed to end the read.
                        bc_vld_d = 1'b1; bc_op_d = OP_READ; bc_tx_d = 8'h00; bc_mack_d = ~last_byte;
                    end
                end
                S_STOP: if (byte_done) begin
                    state_d = S_DONE; finish_d = 1'b1; status_d[ST_BUSY] = 1'b0;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;   cmd_q     <= '0;       addr_q    <= '0;
            cnt_q     <= '0;       pend_q    <= 1'b0;     bc_vld_q  <= 1'b0;
            bc_op_q   <= OP_START; bc_tx_q   <= 8'h00;    bc_mack_q <= 1'b0;
            finish_q  <= 1'b0;     status_q  <= '0;       rd_vld_q  <= 1'b0;
            rd_data_q <= '0;       rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;   cmd_q     <= cmd_d;     addr_q    <= addr_d;
            cnt_q     <= cnt_d;     pend_q    <= pend_d;    bc_vld_q  <= bc_vld_d;
            bc_op_q   <= bc_op_d;   bc_tx_q   <= bc_tx_d;   bc_mack_q <= bc_mack_d;
            finish_q  <= finish_d;  status_q  <= status_d;  rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d; rd_last_q <= rd_last_d;
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer: stimulus pushes expected engine
// requests / read bytes / completions; a monitor pops and compares them.
module tb_i2c_cmd_sequencer;
    import i2c_seq_pkg::*;

    logic        clock, rst, clk_en;
    logic        cmd_vld, cmd_ready, finish;
    logic [3:0]  cmd;
    logic [14:0] addr;
    logic [23:0] burst_len;
    logic [4:0]  status;
    logic        wr_vld, wr_last, wr_ready;
    logic [7:0]  wr_data;
    logic        rd_vld, rd_last, rd_ready;
    logic [7:0]  rd_data;
    logic        bc_vld, bc_mack, bc_ready, bc_done, bc_nack;
    logic [1:0]  bc_op;
    logic [7:0]  bc_tx, bc_rx;

    i2c_cmd_sequencer dut (
        .clock(clock), .rst(rst), .clk_en(clk_en),
        .cmd_vld(cmd_vld), .cmd(cmd), .addr(addr), .burst_len(burst_len),
        .cmd_ready(cmd_ready), .finish(finish), .status(status),
        .wr_vld(wr_vld), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
        .rd_vld(rd_vld), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
        .bc_vld(bc_vld), .bc_op(bc_op), .bc_tx(bc_tx), .bc_mack(bc_mack),
        .bc_ready(bc_ready), .bc_done(bc_done), .bc_rx(bc_rx), .bc_nack(bc_nack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { int k; logic [1:0] op; logic [7:0] v; logic f; } exp_t;
    localparam int EV_BC = 0, EV_RD = 1, EV_FIN = 2;

    exp_t       exp_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] rx_q[$];
    int n_chk = 0, n_fail = 0;
    int eng_req = 0, nack_at = 0;
    int wr_rdy_cnt = 0, bc_vld_cnt = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic fail_now(string nm);
        n_chk++; n_fail++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    task automatic push(int k, logic [1:0] op, logic [7:0] v, logic f);
        exp_t e;
        e.k = k; e.op = op; e.v = v; e.f = f;
        exp_q.push_back(e);
    endtask

    task automatic expect_evt(int k, logic [1:0] op, logic [7:0] v, logic f);
        exp_t e;
        logic bad;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d op=%0d val=%h flag=%b, none expected", k, op, v, f);
            return;
        end
        e = exp_q.pop_front();
        bad = (e.k != k);
        if (!bad && k == EV_BC) begin
            bad = (e.op != op) || (op == OP_WRITE && v !== e.v) || (op == OP_READ && f !== e.f);
        end else if (!bad) begin
            bad = (v !== e.v) || (f !== e.f);
        end
        if (bad) begin
            n_fail++;
            $display("FAIL event: got kind=%0d op=%0d val=%h flag=%b, expected kind=%0d op=%0d val=%h flag=%b",
                     k, op, v, f, e.k, e.op, e.v, e.f);
        end
    endtask

    // Monitor: everything the DUT presents is checked against the scoreboard.
    initial forever begin
        @(negedge clock);
        if (!rst) begin
            if (wr_ready) wr_rdy_cnt++;
            if (bc_vld)   bc_vld_cnt++;
            if (rd_vld && rd_ready) expect_evt(EV_RD, 2'd0, rd_data, rd_last);
            if (bc_vld && bc_ready) expect_evt(EV_BC, bc_op, bc_tx, bc_mack);
            if (finish)             expect_evt(EV_FIN, 2'd0, {3'b000, status}, 1'b0);
        end
    end

    // Byte engine: always ready, completes each byte two cycles after acceptance.
    initial begin
        logic     e_pend;
        int       e_dly;
        logic [1:0] e_op;
        e_pend = 1'b0; e_dly = 0; e_op = 2'd0;
        bc_done = 1'b0; bc_nack = 1'b0; bc_rx = 8'h00;
        forever begin
            @(negedge clock);
            bc_done = 1'b0; bc_nack = 1'b0;
            if (rst) begin
                e_pend = 1'b0;
            end else if (e_pend) begin
                if (e_dly == 0) begin
                    bc_done = 1'b1;
                    bc_nack = (eng_req == nack_at);
                    if (e_op == OP_READ && rx_q.size() > 0) bc_rx = rx_q.pop_front();
                    e_pend = 1'b0;
                end else e_dly--;
            end else if (bc_vld && bc_ready) begin
                e_pend = 1'b1; e_dly = 1; e_op = bc_op; eng_req++;
            end
        end
    end

    // Write-stream source fed from wr_q.
    initial begin
        logic fire;
        wr_vld = 1'b0; wr_data = 8'h00; wr_last = 1'b0;
        forever begin
            @(negedge clock);
            fire = wr_vld & wr_ready & ~rst;
            @(posedge clock); #1;
            if (fire && wr_q.size() > 0) void'(wr_q.pop_front());
            if (wr_q.size() > 0) begin
                wr_vld = 1'b1; wr_data = wr_q[0]; wr_last = (wr_q.size() == 1);
            end else begin
                wr_vld = 1'b0; wr_last = 1'b0;
            end
        end
    end

    task automatic send_cmd(logic [3:0] c, logic [14:0] a, logic [23:0] len);
        int t;
        @(posedge clock); #1;
        cmd_vld = 1'b1; cmd = c; addr = a; burst_len = len;
        t = 0;
        do begin @(negedge clock); t++; end while (!cmd_ready && t < 50);
        if (!cmd_ready) fail_now("cmd_accept");
        @(posedge clock); #1;
        cmd_vld = 1'b0;
    endtask

    task automatic wait_finish(string nm);
        int t;
        t = 0;
        do begin @(negedge clock); t++; end while (!finish && t < 400);
        if (!finish) fail_now(nm);
        else begin
            @(negedge clock);
            chk({nm, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
        end
    endtask

    task automatic push_hdr(logic [7:0] dev_w);
        push(EV_BC, OP_START, 8'h00, 1'b0);
        push(EV_BC, OP_WRITE, dev_w, 1'b0);
        push(EV_BC, OP_WRITE, 8'hA3, 1'b0);
    endtask

    task automatic push_read2(logic [7:0] b0, logic [7:0] b1);
        push_hdr(8'hA0);
        push(EV_BC, OP_START, 8'h00, 1'b0);
        push(EV_BC, OP_WRITE, 8'hA1, 1'b0);
        push(EV_BC, OP_READ, 8'h00, 1'b1);
        push(EV_RD, 2'd0, b0, 1'b0);
        push(EV_BC, OP_READ, 8'h00, 1'b0);
        push(EV_RD, 2'd0, b1, 1'b1);
        push(EV_BC, OP_STOP, 8'h00, 1'b0);
        push(EV_FIN, 2'd0, 8'h00, 1'b0);
        rx_q.push_back(b0); rx_q.push_back(b1);
    endtask

    initial begin
        int t, snap;
        rst = 1'b1; clk_en = 1'b1; bc_ready = 1'b1; rd_ready = 1'b1;
        cmd_vld = 1'b0; cmd = 4'd0; addr = 15'd0; burst_len = 24'd0;

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clock); #1 rst = 1'b0;
        @(negedge clock);
        chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rel_outputs", {11'd0, finish, status, wr_ready, rd_vld, rd_last, bc_vld, bc_op, bc_tx, bc_mack}, 32'd0);

        // WRITE 3 bytes, all ACK
        nack_at = -1;
        push_hdr(8'hA0);
        push(EV_BC, OP_WRITE, 8'h11, 1'b0);
        push(EV_BC, OP_WRITE, 8'h22, 1'b0);
        push(EV_BC, OP_WRITE, 8'h33, 1'b0);
        push(EV_BC, OP_STOP, 8'h00, 1'b0);
        push(EV_FIN, 2'd0, 8'h00, 1'b0);
        wr_q.push_back(8'h11); wr_q.push_back(8'h22); wr_q.push_back(8'h33);
        send_cmd(4'd0, 15'h50A3, 24'd3);
        @(negedge clock);
        chk("start_after_accept", {29'd0, bc_vld, bc_op, status[0]}, {29'd0, 1'b1, 2'd0, 1'b1});
        wait_finish("write3");

        // READ 2 bytes
        push_read2(8'h5A, 8'hC3);
        send_cmd(4'd1, 15'h50A3, 24'd2);
        wait_finish("read2");

        // READ 2 bytes with the first byte held off for 10 cycles
        rd_ready = 1'b0;
        push_read2(8'h5A, 8'hC3);
        send_cmd(4'd1, 15'h50A3, 24'd2);
        t = 0;
        do begin @(negedge clock); t++; end while (!rd_vld && t < 200);
        if (!rd_vld) fail_now("stall_rd_vld");
        for (int i = 0; i < 10; i++) begin
            chk("stall_rd_data", {23'd0, rd_vld, rd_data}, {23'd0, 1'b1, 8'h5A});
            chk("stall_no_read", {31'd0, bc_vld}, 32'd0);
            @(negedge clock);
        end
        @(posedge clock); #1 rd_ready = 1'b1;
        wait_finish("read_stall");

        // NACK on device address
        snap = wr_rdy_cnt;
        nack_at = eng_req + 2;
        push(EV_BC, OP_START, 8'h00, 1'b0);
        push(EV_BC, OP_WRITE, 8'hA0, 1'b0);
        push(EV_BC, OP_STOP, 8'h00, 1'b0);
        push(EV_FIN, 2'd0, 8'h02, 1'b0);
        send_cmd(4'd0, 15'h50A3, 24'd2);
        wait_finish("dev_nack");
        chk("dev_nack_no_wr_ready", wr_rdy_cnt - snap, 32'd0);
        nack_at = -1;

        // Illegal command, then zero length: finish two cycles after accept
        for (int j = 0; j < 2; j++) begin
            snap = bc_vld_cnt;
            push(EV_FIN, 2'd0, (j == 0) ? 8'h08 : 8'h10, 1'b0);
            send_cmd((j == 0) ? 4'd7 : 4'd0, 15'h50A3, (j == 0) ? 24'd1 : 24'd0);
            @(negedge clock);
            chk("bad_cmd_finish_n1", {31'd0, finish}, 32'd0);
            @(negedge clock);
            chk("bad_cmd_finish_n2", {31'd0, finish}, 32'd1);
            @(negedge clock);
            chk("bad_cmd_ready_n3", {31'd0, cmd_ready}, 32'd1);
            chk("bad_cmd_no_bc_vld", bc_vld_cnt - snap, 32'd0);
        end

        // Reset in the middle of a write after the first of three bytes
        push_hdr(8'hA0);
        push(EV_BC, OP_WRITE, 8'h11, 1'b0);
        wr_q.push_back(8'h11);
        send_cmd(4'd0, 15'h50A3, 24'd3);
        t = 0;
        do begin @(negedge clock); t++; end while (!(wr_ready && !wr_vld) && t < 200);
        if (!(wr_ready && !wr_vld)) fail_now("mid_write_idle");
        chk("pre_reset_drained", exp_q.size(), 32'd0);
        @(posedge clock); #1 rst = 1'b1;
        @(negedge clock);
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clock); #1 rst = 1'b0;
        @(negedge clock);
        chk("post_rst_idle", {30'd0, cmd_ready, bc_vld}, {30'd0, 1'b1, 1'b0});

        push_hdr(8'hA0);
        push(EV_BC, OP_WRITE, 8'h77, 1'b0);
        push(EV_BC, OP_STOP, 8'h00, 1'b0);
        push(EV_FIN, 2'd0, 8'h00, 1'b0);
        wr_q.push_back(8'h77);
        send_cmd(4'd0, 15'h50A3, 24'd1);
        wait_finish("post_rst_write");

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
